// File: rtl/adder_tree_arbiter.sv
// Round-robin front end sharing one adder_tree between NUM_REQ requesters.
// A tag FIFO of requester IDs steers each in-order tree result back to its issuer.
module adder_tree_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int NUM_INPUTS   = 10,
   parameter int INPUT_WIDTH  = 16,
   parameter int OUTPUT_WIDTH = 16,
   parameter int TAG_DEPTH    = 8
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic [NUM_REQ-1:0]                                    req_valid,
   output logic [NUM_REQ-1:0]                                    req_ready,
   input  logic [NUM_REQ-1:0][NUM_INPUTS-1:0][INPUT_WIDTH-1:0]   req_data,
   output logic                                                  tree_valid_in,
   output logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]                tree_data_in,
   input  logic                                                  tree_valid_out,
   input  logic [OUTPUT_WIDTH-1:0]                               tree_data_out,
   output logic [NUM_REQ-1:0]                                    res_valid,
   output logic [OUTPUT_WIDTH-1:0]                               res_data,
   output logic                                                  busy,
   output logic                                                  err_unexpected
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CNT_W  = $clog2(TAG_DEPTH + 1);

   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  gnt_idx;
   logic              gnt_found;
   logic [PTR_W-1:0]  tag_mem [TAG_DEPTH];
   logic [TAG_AW-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              can_issue, fire, pop;

   // Scan from ptr upward, wrapping at NUM_REQ; the first valid requester wins.
   always_comb begin
      int j;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      j         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!gnt_found && req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = PTR_W'(j);
         end
      end
   end

   // Full test looks only at the registered count, so a same-cycle pop never frees a slot early.
   assign can_issue = (count < CNT_W'(TAG_DEPTH));
   assign fire      = gnt_found & can_issue;
   assign pop       = tree_valid_out & (count != '0);

   always_comb begin
      req_ready = '0;
      if (fire) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      count_nxt = count;
      case ({fire, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (fire) tag_mem[wr_ptr] <= gnt_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr            <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         busy           <= 1'b0;
         tree_valid_in  <= 1'b0;
         tree_data_in   <= '0;
         res_valid      <= '0;
         res_data       <= '0;
         err_unexpected <= 1'b0;
      end else begin
         tree_valid_in <= fire;
         if (fire) begin
            tree_data_in <= req_data[gnt_idx];
            ptr          <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            wr_ptr       <= (wr_ptr == TAG_AW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + TAG_AW'(1);
         end
         if (pop) begin
            res_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
            res_data  <= tree_data_out;
            rd_ptr    <= (rd_ptr == TAG_AW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + TAG_AW'(1);
         end else begin
            res_valid <= '0;
         end
         // A result with no outstanding tag can't be routed; latch it until reset.
         if (tree_valid_out && count == '0) err_unexpected <= 1'b1;
         count <= count_nxt;
         busy  <= (count_nxt != '0);
      end
   end

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Bench for adder_tree_arbiter: behavioural tree stub with stall/inject controls,
// a cycle model of arbitration and tags, and per-requester result scoreboards.
module tb_adder_tree_arbiter;
   localparam int N = 4, NI = 10, IW = 16, OW = 16, TD = 8;

   typedef logic [NI-1:0][IW-1:0] vec_t;
   typedef logic [N-1:0][NI-1:0][IW-1:0] rdata_t;
   typedef struct { logic [N-1:0] rv; logic [N-1:0] ready; } vec_s;

   logic           clk = 1'b0, rst = 1'b1;
   logic [N-1:0]   req_valid = '0, req_ready;
   rdata_t         req_data = '0;
   logic           tree_valid_in, tree_valid_out;
   vec_t           tree_data_in;
   logic [OW-1:0]  tree_data_out, res_data;
   logic [N-1:0]   res_valid;
   logic           busy, err_unexpected;

   adder_tree_arbiter #(.NUM_REQ(N), .NUM_INPUTS(NI), .INPUT_WIDTH(IW),
                        .OUTPUT_WIDTH(OW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .tree_valid_in(tree_valid_in), .tree_data_in(tree_data_in),
      .tree_valid_out(tree_valid_out), .tree_data_out(tree_data_out),
      .res_valid(res_valid), .res_data(res_data), .busy(busy),
      .err_unexpected(err_unexpected));

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] tsum(input vec_t v);
      logic signed [31:0] s;
      s = 0;
      for (int i = 0; i < NI; i++) s = s + {{(32-IW){v[i][IW-1]}}, v[i]};
      return s[OW-1:0];
   endfunction

   function automatic rdata_t fill_all(input logic [IW-1:0] v);
      rdata_t d;
      for (int r = 0; r < N; r++) for (int i = 0; i < NI; i++) d[r][i] = v;
      return d;
   endfunction

   // Tree stub: one-deep in-order pipe; stall holds results, inject fakes an orphan result.
   logic          stall = 1'b0, inject = 1'b0;
   logic [OW-1:0] tq[$];
   always @(posedge clk) begin
      if (rst) begin
         tq.delete();
         tree_valid_out <= 1'b0;
         tree_data_out  <= '0;
      end else begin
         if (tree_valid_in) tq.push_back(tsum(tree_data_in));
         if (inject) begin
            tree_valid_out <= 1'b1;
            tree_data_out  <= 16'h5A5A;
         end else if (!stall && tq.size() > 0) begin
            tree_valid_out <= 1'b1;
            tree_data_out  <= tq.pop_front();
         end else begin
            tree_valid_out <= 1'b0;
         end
      end
   end

   int            n_chk = 0, n_pass = 0;
   int            m_ptr = 0;
   int            m_tags[$];
   logic [OW-1:0] exp_q [N][$];
   logic          m_err = 0, exp_tvi = 0, exp_busy = 0;
   vec_t          exp_tdata = '0;
   logic [N-1:0]  exp_rv = '0, last_fire = '0;
   int            fires [N];
   int            res_cnt [N];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic check_regs();
      chk("tree_valid_in", tree_valid_in, exp_tvi);
      if (exp_tvi) chk("tree_data_in", tree_data_in, exp_tdata);
      chk("res_valid", res_valid, exp_rv);
      for (int r = 0; r < N; r++) if (res_valid[r]) begin
         res_cnt[r]++;
         if (exp_q[r].size() == 0) chk("res_unmatched", 1, 0);
         else chk("res_data", res_data, exp_q[r].pop_front());
      end
      chk("busy", busy, exp_busy);
      chk("err_unexpected", err_unexpected, m_err);
   endtask

   task automatic eval();
      int g;
      logic [N-1:0] exp_ready;
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_ready = '0;
      if (g >= 0 && m_tags.size() < TD) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      last_fire = req_valid & req_ready;
      for (int i = 0; i < N; i++) fires[i] += int'(last_fire[i]);
      exp_rv = '0;
      if (tree_valid_out) begin
         if (m_tags.size() > 0) exp_rv[m_tags.pop_front()] = 1'b1;
         else m_err = 1'b1;
      end
      exp_tvi = (exp_ready != '0);
      if (exp_tvi) begin
         m_tags.push_back(g);
         exp_q[g].push_back(tsum(req_data[g]));
         exp_tdata = req_data[g];
         m_ptr = (g + 1) % N;
      end
      exp_busy = (m_tags.size() != 0);
   endtask

   task automatic step(input logic [N-1:0] rv, input rdata_t d);
      @(negedge clk);
      check_regs();
      req_valid = rv;
      req_data  = d;
      #1;
      eval();
   endtask

   task automatic clr_counts();
      for (int i = 0; i < N; i++) begin fires[i] = 0; res_cnt[i] = 0; end
   endtask

   task automatic drain();
      int left;
      stall = 1'b0;
      for (int c = 0; c < 60; c++) begin
         step('0, req_data);
         left = m_tags.size() + tq.size();
         for (int r = 0; r < N; r++) left += exp_q[r].size();
         if (left == 0 && exp_rv == '0) break;
      end
      step('0, req_data);
      left = m_tags.size() + tq.size();
      for (int r = 0; r < N; r++) left += exp_q[r].size();
      chk("drain_empty", left, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid = '0;
      #2 rst = 1'b1;
      #1;
      chk("rst_tree_valid_in", tree_valid_in, 0);
      chk("rst_tree_data_in", tree_data_in, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_unexpected, 0);
      chk("rst_req_ready", req_ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_ptr = 0; m_tags.delete(); m_err = 0;
      for (int r = 0; r < N; r++) exp_q[r].delete();
      exp_tvi = 0; exp_busy = 0; exp_rv = '0; exp_tdata = '0;
   endtask

   vec_s   tbl [8];
   rdata_t d;

   initial begin
      tbl[0] = '{4'b1010, 4'b0010};
      tbl[1] = '{4'b1011, 4'b1000};
      tbl[2] = '{4'b0000, 4'b0000};
      tbl[3] = '{4'b1100, 4'b0100};
      tbl[4] = '{4'b0111, 4'b0001};
      tbl[5] = '{4'b0001, 4'b0001};
      tbl[6] = '{4'b1111, 4'b0010};
      tbl[7] = '{4'b0011, 4'b0001};
      clr_counts();

      // Reset state
      @(negedge clk);
      chk("init_tree_valid_in", tree_valid_in, 0);
      chk("init_res_valid", res_valid, 0);
      chk("init_busy", busy, 0);
      chk("init_err", err_unexpected, 0);
      chk("init_req_ready", req_ready, 0);
      rst = 1'b0;

      // Arbitration table from ptr=0
      for (int i = 0; i < 8; i++) begin
         for (int r = 0; r < N; r++) for (int e = 0; e < NI; e++) d[r][e] = IW'(i * 16 + r + 1);
         step(tbl[i].rv, d);
         chk("tbl_ready", req_ready, tbl[i].ready);
      end
      drain();

      // Single requester, 20 back-to-back vectors of ones
      clr_counts();
      for (int i = 0; i < 20; i++) step(4'b0001, fill_all(16'd1));
      drain();
      chk("t1_fires", fires[0], 20);
      chk("t1_results", res_cnt[0], 20);

      // All requesters, requester i sends value i+1
      clr_counts();
      for (int r = 0; r < N; r++) for (int e = 0; e < NI; e++) d[r][e] = IW'(r + 1);
      for (int i = 0; i < 40; i++) step(4'b1111, d);
      drain();
      for (int r = 0; r < N; r++) begin
         chk("t2_fires", fires[r], 10);
         chk("t2_results", res_cnt[r], 10);
      end

      // Stalled tree: FIFO fills at TAG_DEPTH, one release admits exactly one more
      clr_counts();
      stall = 1'b1;
      for (int i = 0; i < 11; i++) step(4'b0001, fill_all(16'd3));
      chk("t3_ready_full", req_ready, 0);
      chk("t3_busy", busy, 1);
      chk("t3_fires_full", fires[0], TD);
      stall = 1'b0;
      step(4'b0001, fill_all(16'd3));
      stall = 1'b1;
      for (int i = 0; i < 5; i++) step(4'b0001, fill_all(16'd3));
      chk("t3_fires_release", fires[0], TD + 1);
      chk("t3_ready_refull", req_ready, 0);
      drain();

      // Random traffic; requesters hold valid/data until accepted
      begin
         logic [N-1:0] crv;
         rdata_t       cd;
         crv = '0;
         cd  = '0;
         for (int c = 0; c < 500; c++) begin
            for (int r = 0; r < N; r++) if (last_fire[r] || !crv[r]) begin
               crv[r] = ($urandom_range(99) < 70);
               for (int e = 0; e < NI; e++) cd[r][e] = IW'($urandom);
            end
            step(crv, cd);
         end
      end
      drain();
      chk("t4_err", err_unexpected, 0);

      // Orphan result with an empty FIFO sets the sticky error
      inject = 1'b1;
      step('0, req_data);
      inject = 1'b0;
      for (int i = 0; i < 4; i++) step('0, req_data);
      chk("t5_err_sticky", err_unexpected, 1);
      chk("t5_res_valid", res_valid, 0);
      do_reset();
      step('0, req_data);
      chk("t5_err_cleared", err_unexpected, 0);

      // Reset with three issues outstanding, then fresh traffic
      stall = 1'b1;
      for (int r = 0; r < N; r++) for (int e = 0; e < NI; e++) d[r][e] = IW'(7 * (r + 1));
      for (int i = 0; i < 3; i++) step(4'b0111, d);
      step('0, d);
      chk("t6_busy_pre", busy, 1);
      stall = 1'b0;
      do_reset();
      clr_counts();
      for (int r = 0; r < N; r++) for (int e = 0; e < NI; e++) d[r][e] = IW'(r + 9);
      for (int i = 0; i < 8; i++) step(4'b1111, d);
      drain();
      for (int r = 0; r < N; r++) chk("t6_results", res_cnt[r], 2);
      chk("t6_err", err_unexpected, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
